// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch port (IF)
// and the data port (MEM stage). Data has priority; a starvation counter
// forces a fetch grant after STARVE_MAX consecutive data grants that were
// made while fetch was waiting.
//
// Ports:
//   CLK, RST                      clock, async active-low reset
//   if_req/if_addr                fetch request and address
//   if_done/if_rdata              fetch completion pulse, fetched word
//   d_req/d_we/d_be/d_addr/d_wdata data request and payload
//   d_done/d_rdata                data completion pulse, load word
//   err                           completion was a timeout abort
//   mem_req/we/be/addr/wdata      memory request side (held through BUSY)
//   mem_ready/mem_rdata           memory completion and read data
module mem_port_arbiter #(
  parameter int unsigned AW         = 8,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned SW = 4;
  localparam int unsigned TW = 8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic          sel_d, sel_d_nxt;
  logic [SW-1:0] starve_cnt, starve_cnt_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt, tcnt_inc;
  logic          if_done_nxt, d_done_nxt, err_nxt;
  logic [DW-1:0] if_rdata_nxt, d_rdata_nxt;
  logic          mem_req_nxt, mem_we_nxt;
  logic [3:0]    mem_be_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [DW-1:0] mem_wdata_nxt;
  logic          d_win;
  logic          starve_full;

  assign starve_full = (starve_cnt == SW'(STARVE_MAX));
  // Data wins unless fetch is waiting and has been passed over too often.
  assign d_win       = d_req && !(if_req && starve_full);
  assign tcnt_inc    = tcnt + TW'(1);

  // State and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      sel_d      <= 1'b0;
      starve_cnt <= '0;
      tcnt       <= '0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
      err        <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_nxt;
      sel_d      <= sel_d_nxt;
      starve_cnt <= starve_cnt_nxt;
      tcnt       <= tcnt_nxt;
      if_done    <= if_done_nxt;
      d_done     <= d_done_nxt;
      err        <= err_nxt;
      if_rdata   <= if_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_be     <= mem_be_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    sel_d_nxt      = sel_d;
    starve_cnt_nxt = starve_cnt;
    tcnt_nxt       = tcnt;
    if_done_nxt    = 1'b0;
    d_done_nxt     = 1'b0;
    err_nxt        = err;
    if_rdata_nxt   = if_rdata;
    d_rdata_nxt    = d_rdata;
    mem_req_nxt    = mem_req;
    mem_we_nxt     = mem_we;
    mem_be_nxt     = mem_be;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;

    unique case (state)
      IDLE: begin
        if (if_req || d_req) begin
          state_nxt   = BUSY;
          mem_req_nxt = 1'b1;
          err_nxt     = 1'b0;
          tcnt_nxt    = '0;
          if (d_win) begin
            sel_d_nxt     = 1'b1;
            mem_we_nxt    = d_we;
            mem_be_nxt    = d_be;
            mem_addr_nxt  = d_addr;
            mem_wdata_nxt = d_wdata;
            // Count only data grants that actually made fetch wait.
            if (!if_req)          starve_cnt_nxt = '0;
            else if (!starve_full) starve_cnt_nxt = starve_cnt + SW'(1);
          end else begin
            sel_d_nxt      = 1'b0;
            mem_we_nxt     = 1'b0;
            mem_be_nxt     = 4'hF;
            mem_addr_nxt   = if_addr;
            mem_wdata_nxt  = '0;
            starve_cnt_nxt = '0;
          end
        end
      end
      BUSY: begin
        tcnt_nxt = tcnt_inc;
        if (mem_ready) begin
          state_nxt   = DONE;
          mem_req_nxt = 1'b0;
          if (sel_d) begin
            d_rdata_nxt = mem_rdata;
            d_done_nxt  = 1'b1;
          end else begin
            if_rdata_nxt = mem_rdata;
            if_done_nxt  = 1'b1;
          end
        end else if (tcnt_inc == TW'(TIMEOUT)) begin
          // Abort: report completion with err, rdata untouched.
          state_nxt   = DONE;
          mem_req_nxt = 1'b0;
          err_nxt     = 1'b1;
          if (sel_d) d_done_nxt  = 1'b1;
          else       if_done_nxt = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
